// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types and constants for the vending transaction controller
package vend_pkg;

    localparam int CREDIT_W     = 4;
    localparam int SUM_W        = CREDIT_W + 1;
    localparam int COIN_ONE_VAL = 1;
    localparam int COIN_TWO_VAL = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } vend_state_e;

    // Value of the coins presented in one cycle; both together count as 3.
    function automatic logic [SUM_W-1:0] coin_value(input logic one, input logic two);
        logic [SUM_W-1:0] v;
        v = '0;
        if (one) v = v + SUM_W'(COIN_ONE_VAL);
        if (two) v = v + SUM_W'(COIN_TWO_VAL);
        return v;
    endfunction

endpackage

// File: rtl/vend_if.sv
// rtl/vend_if.sv - coin, cancel, dispenser and status signals of the vending controller
interface vend_if;
    import vend_pkg::*;

    logic                coin_one;
    logic                coin_two;
    logic                cancel;
    logic                disp_ack;
    logic [1:0]          state;
    logic [CREDIT_W-1:0] credit;
    logic                disp_req;
    logic                change_pulse;
    logic                coin_reject;

    modport master (
        output coin_one, coin_two, cancel, disp_ack,
        input  state, credit, disp_req, change_pulse, coin_reject
    );

    modport slave (
        input  coin_one, coin_two, cancel, disp_ack,
        output state, credit, disp_req, change_pulse, coin_reject
    );

endinterface

// File: rtl/vend_timer.sv
// rtl/vend_timer.sv - inactivity counter that flags the last cycle of the timeout window
module vend_timer #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int           W    = $clog2(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    // Count enabled cycles; a clear always wins so the count never runs past LAST.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign expired = en && (count == LAST);

endmodule

// File: rtl/vend_ctrl.sv
// rtl/vend_ctrl.sv - coin credit, dispense handshake and change/refund sequencing
module vend_ctrl #(
    parameter int PRICE      = 3,
    parameter int MAX_CREDIT = 7,
    parameter int TIMEOUT    = 1000
) (
    input  logic clk,
    input  logic rst,
    vend_if.slave bus
);
    import vend_pkg::*;

    localparam logic [SUM_W-1:0] PRICE_V = SUM_W'(PRICE);
    localparam logic [SUM_W-1:0] MAX_V   = SUM_W'(MAX_CREDIT);

    vend_state_e         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                reject_q, reject_d;

    logic [SUM_W-1:0]    coin_v;
    logic [SUM_W-1:0]    credit_ext;
    logic [SUM_W-1:0]    credit_sum;
    logic [SUM_W-1:0]    remainder;
    logic                coin_ok;
    logic                coin_acc;
    logic                tmr_clr;
    logic                tmr_en;
    logic                tmr_expired;

    // Widen before adding so an overflowing coin is detected rather than wrapped.
    assign coin_v     = coin_value(bus.coin_one, bus.coin_two);
    assign credit_ext = SUM_W'(credit_q);
    assign credit_sum = credit_ext + coin_v;
    assign remainder  = credit_ext - PRICE_V;

    // A coin is only taken while collecting credit, never alongside a cancel.
    assign coin_ok  = ((state_q == IDLE) || (state_q == CREDIT)) && !bus.cancel
                      && (credit_sum <= MAX_V);
    assign coin_acc = coin_ok && (coin_v != '0);

    // The inactivity window restarts on every accepted coin and whenever CREDIT is left.
    assign tmr_en  = (state_q == CREDIT);
    assign tmr_clr = coin_acc || (state_d != CREDIT);

    vend_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // State, credit and reject flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            reject_q <= reject_d;
        end
    end

    // Next state and credit; cancel outranks a same-cycle coin, a coin outranks the timeout.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = (coin_v != '0) && !coin_ok;
        case (state_q)
            IDLE: begin
                if (coin_acc) begin
                    credit_d = credit_sum[CREDIT_W-1:0];
                    state_d  = (credit_sum >= PRICE_V) ? VEND : CREDIT;
                end
            end
            CREDIT: begin
                if (bus.cancel) begin
                    state_d = CHANGE;
                end else if (coin_acc) begin
                    credit_d = credit_sum[CREDIT_W-1:0];
                    state_d  = (credit_sum >= PRICE_V) ? VEND : CREDIT;
                end else if (tmr_expired) begin
                    state_d = CHANGE;
                end
            end
            VEND: begin
                if (bus.disp_ack) begin
                    credit_d = remainder[CREDIT_W-1:0];
                    state_d  = (remainder != '0) ? CHANGE : IDLE;
                end
            end
            CHANGE: begin
                if (credit_q <= CREDIT_W'(1)) begin
                    credit_d = '0;
                    state_d  = IDLE;
                end else begin
                    credit_d = credit_q - CREDIT_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase
    end

    assign bus.state        = state_q;
    assign bus.credit       = credit_q;
    assign bus.disp_req     = (state_q == VEND);
    assign bus.change_pulse = (state_q == CHANGE);
    assign bus.coin_reject  = reject_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// tb/tb_vend_ctrl.sv - directed and randomized self-checking bench for vend_ctrl
module tb_vend_ctrl;

    localparam int TB_TIMEOUT = 16;
    localparam int TB_MAX     = 7;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    int   m_price [2] = '{3, 6};
    int   m_state [2];
    int   m_credit[2];
    int   m_idle  [2];
    int   m_reject[2];

    vend_if ifa ();
    vend_if ifb ();

    vend_ctrl #(.PRICE(3), .MAX_CREDIT(TB_MAX), .TIMEOUT(TB_TIMEOUT)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    vend_ctrl #(.PRICE(6), .MAX_CREDIT(TB_MAX), .TIMEOUT(TB_TIMEOUT)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifa.coin_one = 0; ifa.coin_two = 0; ifa.cancel = 0; ifa.disp_ack = 0;
        ifb.coin_one = 0; ifb.coin_two = 0; ifb.cancel = 0; ifb.disp_ack = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    // Counts refund pulses until the unit returns to IDLE (bounded).
    task automatic count_pulses(input int d, output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if ((d == 0 ? ifa.state : ifb.state) == 2'd0) break;
            if ((d == 0 ? ifa.change_pulse : ifb.change_pulse) == 1'b1) n++;
            tick();
        end
    endtask

    // Reference model: transaction rules applied to plain integers once per clock.
    task automatic model_step(input int d, input bit c1, input bit c2, input bit cn, input bit ak);
        int v, sum;
        bit ok, acc;
        v   = int'(c1) + 2 * int'(c2);
        sum = m_credit[d] + v;
        ok  = (m_state[d] == 0 || m_state[d] == 1) && !cn && (sum <= TB_MAX);
        acc = ok && (v > 0);
        m_reject[d] = ((v > 0) && !ok) ? 1 : 0;
        case (m_state[d])
            0: if (acc) begin
                m_credit[d] = sum;
                m_state[d]  = (sum >= m_price[d]) ? 2 : 1;
            end
            1: if (cn) begin
                m_state[d] = 3; m_idle[d] = 0;
            end else if (acc) begin
                m_credit[d] = sum; m_idle[d] = 0;
                m_state[d]  = (sum >= m_price[d]) ? 2 : 1;
            end else if (m_idle[d] == TB_TIMEOUT - 1) begin
                m_state[d] = 3; m_idle[d] = 0;
            end else begin
                m_idle[d]++;
            end
            2: if (ak) begin
                m_credit[d] = m_credit[d] - m_price[d];
                m_state[d]  = (m_credit[d] > 0) ? 3 : 0;
            end
            default: begin
                m_credit[d]--;
                if (m_credit[d] == 0) m_state[d] = 0;
            end
        endcase
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        tick();
        checks++;
        if (ifa.state !== 2'd0 || ifa.credit !== 4'd0) begin
            errors++; $display("FAIL reset_a state=%0d credit=%0d expected 0 0", ifa.state, ifa.credit);
        end
        checks++;
        if (ifa.disp_req !== 1'b0 || ifa.change_pulse !== 1'b0 || ifa.coin_reject !== 1'b0) begin
            errors++; $display("FAIL reset_a_flags req=%b pulse=%b rej=%b expected 0", ifa.disp_req, ifa.change_pulse, ifa.coin_reject);
        end
        checks++;
        if (ifb.state !== 2'd0 || ifb.credit !== 4'd0 || ifb.disp_req !== 1'b0) begin
            errors++; $display("FAIL reset_b state=%0d credit=%0d req=%b expected 0", ifb.state, ifb.credit, ifb.disp_req);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_exact_price();
        do_reset();
        ifa.coin_one = 1; tick(); ifa.coin_one = 0;
        checks++;
        if (ifa.credit !== 4'd1 || ifa.state !== 2'd1) begin
            errors++; $display("FAIL exact_coin1 credit=%0d state=%0d expected 1 1", ifa.credit, ifa.state);
        end
        tick();
        ifa.coin_one = 1; tick(); ifa.coin_one = 0;
        checks++;
        if (ifa.credit !== 4'd2 || ifa.state !== 2'd1) begin
            errors++; $display("FAIL exact_coin2 credit=%0d state=%0d expected 2 1", ifa.credit, ifa.state);
        end
        tick();
        ifa.coin_one = 1; tick(); ifa.coin_one = 0;
        checks++;
        if (ifa.state !== 2'd2 || ifa.disp_req !== 1'b1 || ifa.credit !== 4'd3) begin
            errors++; $display("FAIL exact_vend state=%0d req=%b credit=%0d expected 2 1 3", ifa.state, ifa.disp_req, ifa.credit);
        end
        tick(); tick();
        checks++;
        if (ifa.disp_req !== 1'b1) begin
            errors++; $display("FAIL exact_req_hold req=%b expected 1", ifa.disp_req);
        end
        ifa.disp_ack = 1; tick(); ifa.disp_ack = 0;
        checks++;
        if (ifa.state !== 2'd0 || ifa.credit !== 4'd0 || ifa.disp_req !== 1'b0 || ifa.change_pulse !== 1'b0) begin
            errors++; $display("FAIL exact_ack state=%0d credit=%0d req=%b pulse=%b expected 0 0 0 0",
                               ifa.state, ifa.credit, ifa.disp_req, ifa.change_pulse);
        end
        tick();
        checks++;
        if (ifa.change_pulse !== 1'b0 || ifa.state !== 2'd0) begin
            errors++; $display("FAIL exact_no_change pulse=%b state=%0d expected 0 0", ifa.change_pulse, ifa.state);
        end
    endtask

    task automatic test_change();
        int n;
        do_reset();
        ifa.coin_two = 1; tick();
        checks++;
        if (ifa.credit !== 4'd2 || ifa.state !== 2'd1) begin
            errors++; $display("FAIL change_coin1 credit=%0d state=%0d expected 2 1", ifa.credit, ifa.state);
        end
        tick(); ifa.coin_two = 0;
        checks++;
        if (ifa.credit !== 4'd4 || ifa.state !== 2'd2) begin
            errors++; $display("FAIL change_vend credit=%0d state=%0d expected 4 2", ifa.credit, ifa.state);
        end
        ifa.disp_ack = 1; tick();
        checks++;
        if (ifa.state !== 2'd3 || ifa.credit !== 4'd1 || ifa.change_pulse !== 1'b1) begin
            errors++; $display("FAIL change_enter state=%0d credit=%0d pulse=%b expected 3 1 1", ifa.state, ifa.credit, ifa.change_pulse);
        end
        count_pulses(0, n);
        ifa.disp_ack = 0;
        checks++;
        if (n !== 1 || ifa.state !== 2'd0 || ifa.credit !== 4'd0) begin
            errors++; $display("FAIL change_count pulses=%0d state=%0d credit=%0d expected 1 0 0", n, ifa.state, ifa.credit);
        end
    endtask

    task automatic test_overflow_reject();
        int n;
        do_reset();
        ifb.coin_two = 1; tick(); tick(); ifb.coin_two = 0;
        ifb.coin_one = 1; tick(); ifb.coin_one = 0;
        checks++;
        if (ifb.credit !== 4'd5 || ifb.state !== 2'd1 || ifb.coin_reject !== 1'b0) begin
            errors++; $display("FAIL ovf_setup credit=%0d state=%0d rej=%b expected 5 1 0", ifb.credit, ifb.state, ifb.coin_reject);
        end
        ifb.coin_one = 1; ifb.coin_two = 1; tick(); ifb.coin_one = 0; ifb.coin_two = 0;
        checks++;
        if (ifb.coin_reject !== 1'b1 || ifb.credit !== 4'd5 || ifb.state !== 2'd1) begin
            errors++; $display("FAIL ovf_reject rej=%b credit=%0d state=%0d expected 1 5 1", ifb.coin_reject, ifb.credit, ifb.state);
        end
        ifb.coin_two = 1; tick(); ifb.coin_two = 0;
        checks++;
        if (ifb.coin_reject !== 1'b0 || ifb.credit !== 4'd7 || ifb.state !== 2'd2) begin
            errors++; $display("FAIL ovf_fill rej=%b credit=%0d state=%0d expected 0 7 2", ifb.coin_reject, ifb.credit, ifb.state);
        end
        ifb.coin_one = 1; tick(); ifb.coin_one = 0;
        checks++;
        if (ifb.coin_reject !== 1'b1 || ifb.credit !== 4'd7 || ifb.state !== 2'd2) begin
            errors++; $display("FAIL ovf_vend_reject rej=%b credit=%0d state=%0d expected 1 7 2", ifb.coin_reject, ifb.credit, ifb.state);
        end
        ifb.disp_ack = 1; tick(); ifb.disp_ack = 0;
        count_pulses(1, n);
        checks++;
        if (n !== 1 || ifb.state !== 2'd0 || ifb.credit !== 4'd0) begin
            errors++; $display("FAIL ovf_change pulses=%0d state=%0d credit=%0d expected 1 0 0", n, ifb.state, ifb.credit);
        end
    endtask

    task automatic test_cancel();
        int n;
        do_reset();
        ifa.cancel = 1; tick(); ifa.cancel = 0;
        checks++;
        if (ifa.state !== 2'd0 || ifa.change_pulse !== 1'b0) begin
            errors++; $display("FAIL cancel_idle state=%0d pulse=%b expected 0 0", ifa.state, ifa.change_pulse);
        end
        ifa.coin_two = 1; tick(); ifa.coin_two = 0;
        ifa.cancel = 1; ifa.coin_one = 1; tick(); ifa.cancel = 0; ifa.coin_one = 0;
        checks++;
        if (ifa.state !== 2'd3 || ifa.credit !== 4'd2 || ifa.coin_reject !== 1'b1) begin
            errors++; $display("FAIL cancel_enter state=%0d credit=%0d rej=%b expected 3 2 1", ifa.state, ifa.credit, ifa.coin_reject);
        end
        count_pulses(0, n);
        checks++;
        if (n !== 2 || ifa.state !== 2'd0 || ifa.credit !== 4'd0) begin
            errors++; $display("FAIL cancel_refund pulses=%0d state=%0d credit=%0d expected 2 0 0", n, ifa.state, ifa.credit);
        end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        ifa.coin_one = 1; tick(); ifa.coin_one = 0;
        for (int i = 0; i < TB_TIMEOUT - 1; i++) tick();
        checks++;
        if (ifa.state !== 2'd1) begin
            errors++; $display("FAIL timeout_early state=%0d expected 1", ifa.state);
        end
        tick();
        checks++;
        if (ifa.state !== 2'd3 || ifa.change_pulse !== 1'b1) begin
            errors++; $display("FAIL timeout_fire state=%0d pulse=%b expected 3 1", ifa.state, ifa.change_pulse);
        end
        count_pulses(0, n);
        checks++;
        if (n !== 1 || ifa.state !== 2'd0) begin
            errors++; $display("FAIL timeout_refund pulses=%0d state=%0d expected 1 0", n, ifa.state);
        end
        ifa.coin_one = 1; tick(); ifa.coin_one = 0;
        for (int i = 0; i < 9; i++) tick();
        ifa.coin_one = 1; tick(); ifa.coin_one = 0;
        for (int i = 0; i < TB_TIMEOUT - 1; i++) tick();
        checks++;
        if (ifa.state !== 2'd1 || ifa.credit !== 4'd2) begin
            errors++; $display("FAIL timeout_restart state=%0d credit=%0d expected 1 2", ifa.state, ifa.credit);
        end
        tick();
        count_pulses(0, n);
        checks++;
        if (n !== 2 || ifa.state !== 2'd0) begin
            errors++; $display("FAIL timeout_restart_refund pulses=%0d state=%0d expected 2 0", n, ifa.state);
        end
    endtask

    task automatic test_reset_mid_vend();
        do_reset();
        ifa.coin_two = 1; ifa.coin_one = 1; tick(); ifa.coin_two = 0; ifa.coin_one = 0;
        checks++;
        if (ifa.state !== 2'd2 || ifa.disp_req !== 1'b1) begin
            errors++; $display("FAIL rstvend_setup state=%0d req=%b expected 2 1", ifa.state, ifa.disp_req);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (ifa.state !== 2'd0 || ifa.credit !== 4'd0 || ifa.disp_req !== 1'b0) begin
            errors++; $display("FAIL rstvend_async state=%0d credit=%0d req=%b expected 0 0 0", ifa.state, ifa.credit, ifa.disp_req);
        end
        ifa.disp_ack = 1;
        tick();
        rst = 1'b1;
        tick();
        tick();
        ifa.disp_ack = 0;
        checks++;
        if (ifa.state !== 2'd0 || ifa.credit !== 4'd0 || ifa.disp_req !== 1'b0 || ifa.change_pulse !== 1'b0) begin
            errors++; $display("FAIL rstvend_late_ack state=%0d credit=%0d req=%b pulse=%b expected 0 0 0 0",
                               ifa.state, ifa.credit, ifa.disp_req, ifa.change_pulse);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int d = 0; d < 2; d++) begin
            m_state[d] = 0; m_credit[d] = 0; m_idle[d] = 0; m_reject[d] = 0;
        end
        for (int ph = 0; ph < 3; ph++) begin
            for (int cyc = 0; cyc < 600; cyc++) begin
                bit c1 [2];
                bit c2 [2];
                bit cn [2];
                bit ak [2];
                int coin_pct;
                int ack_pct;
                coin_pct = (ph == 1) ? 3 : 25;
                ack_pct  = (ph == 2) ? 70 : 25;
                for (int d = 0; d < 2; d++) begin
                    c1[d] = ($urandom_range(99) < coin_pct);
                    c2[d] = ($urandom_range(99) < coin_pct);
                    cn[d] = ($urandom_range(99) < 4);
                    ak[d] = ($urandom_range(99) < ack_pct);
                    model_step(d, c1[d], c2[d], cn[d], ak[d]);
                end
                ifa.coin_one = c1[0]; ifa.coin_two = c2[0]; ifa.cancel = cn[0]; ifa.disp_ack = ak[0];
                ifb.coin_one = c1[1]; ifb.coin_two = c2[1]; ifb.cancel = cn[1]; ifb.disp_ack = ak[1];
                tick();
                for (int d = 0; d < 2; d++) begin
                    logic [1:0] os;
                    logic [3:0] oc;
                    logic       odr, ocp, orj;
                    os  = (d == 0) ? ifa.state        : ifb.state;
                    oc  = (d == 0) ? ifa.credit       : ifb.credit;
                    odr = (d == 0) ? ifa.disp_req     : ifb.disp_req;
                    ocp = (d == 0) ? ifa.change_pulse : ifb.change_pulse;
                    orj = (d == 0) ? ifa.coin_reject  : ifb.coin_reject;
                    checks++;
                    if (os !== 2'(m_state[d])) begin
                        errors++; $display("FAIL rand_state dut%0d ph%0d cyc%0d got=%0d exp=%0d", d, ph, cyc, os, m_state[d]);
                    end
                    checks++;
                    if (oc !== 4'(m_credit[d])) begin
                        errors++; $display("FAIL rand_credit dut%0d ph%0d cyc%0d got=%0d exp=%0d", d, ph, cyc, oc, m_credit[d]);
                    end
                    checks++;
                    if (odr !== (m_state[d] == 2)) begin
                        errors++; $display("FAIL rand_disp_req dut%0d ph%0d cyc%0d got=%b exp=%b", d, ph, cyc, odr, m_state[d] == 2);
                    end
                    checks++;
                    if (ocp !== (m_state[d] == 3)) begin
                        errors++; $display("FAIL rand_change dut%0d ph%0d cyc%0d got=%b exp=%b", d, ph, cyc, ocp, m_state[d] == 3);
                    end
                    checks++;
                    if (orj !== 1'(m_reject[d])) begin
                        errors++; $display("FAIL rand_reject dut%0d ph%0d cyc%0d got=%b exp=%0d", d, ph, cyc, orj, m_reject[d]);
                    end
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_exact_price();
        test_change();
        test_overflow_reject();
        test_cancel();
        test_timeout();
        test_reset_mid_vend();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
